// File: rtl/ps2_note_tracker_if.sv
// Byte-stream input and piano key-state output bundle between the PS/2 receiver,
// the note tracker and the VGA piano renderer.
interface ps2_note_tracker_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic [6:0] keyNum;
  logic       newPress;
  logic       pending;

  modport master (
    output ps2_byte, ps2_byte_en,
    input  keyNum, newPress, pending
  );

  modport slave (
    input  ps2_byte, ps2_byte_en,
    output keyNum, newPress, pending
  );
endinterface

// File: rtl/ps2_note_tracker.sv
// Decodes set-2 make/break codes for keys A..G into a target state and releases
// changes to the renderer one bit at a time, spaced by a redraw holdoff.
module ps2_note_tracker #(
  parameter int unsigned HOLDOFF   = 600,
  parameter int unsigned HOLDOFF_N = 10
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  ps2_note_tracker_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic [6:0]           target_q, target_d;
  logic [6:0]           key_q, key_d;
  logic                 press_q, press_d;
  logic [HOLDOFF_N-1:0] hold_q, hold_d;

  logic [6:0]           map_mask;
  logic [6:0]           diff;
  logic [6:0]           lowest;
  logic                 fire;

  always_comb begin
    map_mask = '0;
    case (bus.ps2_byte)
      8'h1C:   map_mask = 7'b0000001;
      8'h32:   map_mask = 7'b0000010;
      8'h21:   map_mask = 7'b0000100;
      8'h23:   map_mask = 7'b0001000;
      8'h24:   map_mask = 7'b0010000;
      8'h2B:   map_mask = 7'b0100000;
      8'h34:   map_mask = 7'b1000000;
      default: map_mask = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      key_q    <= '0;
      press_q  <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      key_q    <= key_d;
      press_q  <= press_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.ps2_byte_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.ps2_byte == 8'hF0)      state_d = S_BREAK;
          else if (bus.ps2_byte == 8'hE0) state_d = S_EXT;
          else                            state_d = S_IDLE;
        end
        S_EXT:   state_d = (bus.ps2_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    target_d = target_q;
    if (bus.ps2_byte_en) begin
      case (state_q)
        S_IDLE:  target_d = target_q | map_mask;
        S_BREAK: target_d = target_q & ~map_mask;
        default: target_d = target_q;
      endcase
    end
  end

  // Release works from registered target, so a byte landing on the same edge
  // only becomes visible to the next release opportunity.
  assign diff   = target_q ^ key_q;
  assign lowest = diff & (~diff + 7'd1);
  assign fire   = (hold_q == '0) && (diff != '0);

  always_comb begin
    key_d   = key_q;
    press_d = 1'b0;
    hold_d  = hold_q;
    if (fire) begin
      key_d   = key_q ^ lowest;
      press_d = 1'b1;
      hold_d  = HOLDOFF_N'(HOLDOFF - 1);
    end else if (hold_q != '0) begin
      hold_d  = hold_q - 1'b1;
    end
  end

  assign bus.keyNum   = key_q;
  assign bus.newPress = press_q;
  assign bus.pending  = (diff != '0);

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Directed bench for ps2_note_tracker: a frame-level scan-code model with a
// cycle-deadline release scheduler checked every cycle, plus literal expectations.
module tb_ps2_note_tracker;

  localparam int unsigned HOLDOFF = 600;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ps2_note_tracker_if bus();

  ps2_note_tracker #(.HOLDOFF(HOLDOFF), .HOLDOFF_N(10)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: bytes are grouped into complete frames ([x], [F0 x], [E0 x], [E0 F0 x]);
  // releases are allowed once the cycle count reaches the next permitted deadline.
  logic [6:0] tgt_m, key_m;
  logic       press_m;
  int         mcyc, ready_at;
  logic [7:0] frame[$];

  function automatic int map_idx(input logic [7:0] b);
    case (b)
      8'h1C: return 0;
      8'h32: return 1;
      8'h21: return 2;
      8'h23: return 3;
      8'h24: return 4;
      8'h2B: return 5;
      8'h34: return 6;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tgt_m = '0; key_m = '0; press_m = 1'b0; mcyc = 0; ready_at = 0;
      frame.delete();
    end else begin
      press_m = 1'b0;
      if (mcyc >= ready_at && tgt_m != key_m) begin
        logic found;
        found = 1'b0;
        for (int i = 0; i < 7; i++)
          if (!found && tgt_m[i] != key_m[i]) begin
            key_m[i] = tgt_m[i];
            found = 1'b1;
          end
        press_m  = 1'b1;
        ready_at = mcyc + HOLDOFF;
      end
      if (bus.ps2_byte_en) begin
        logic [7:0] b;
        b = bus.ps2_byte;
        frame.push_back(b);
        if (!((frame.size() == 1 && (b == 8'hF0 || b == 8'hE0)) ||
              (frame.size() == 2 && frame[0] == 8'hE0 && b == 8'hF0))) begin
          int idx;
          if (frame.size() == 1) begin
            idx = map_idx(frame[0]);
            if (idx >= 0) tgt_m[idx] = 1'b1;
          end else if (frame.size() == 2 && frame[0] == 8'hF0) begin
            idx = map_idx(frame[1]);
            if (idx >= 0) tgt_m[idx] = 1'b0;
          end
          frame.delete();
        end
      end
      mcyc++;
    end
  end

  // Every-cycle comparison and pulse log, sampled on the falling edge.
  int         pulse_cnt = 0;
  int         pulse_t[$];
  logic [6:0] pulse_k[$];

  always @(negedge clk) begin
    checks++;
    if (bus.keyNum !== key_m) begin
      errors++;
      $display("FAIL keyNum cyc=%0d got=%b exp=%b", cyc, bus.keyNum, key_m);
    end
    checks++;
    if (bus.newPress !== press_m) begin
      errors++;
      $display("FAIL newPress cyc=%0d got=%b exp=%b", cyc, bus.newPress, press_m);
    end
    checks++;
    if (bus.pending !== (tgt_m != key_m)) begin
      errors++;
      $display("FAIL pending cyc=%0d got=%b exp=%b", cyc, bus.pending, (tgt_m != key_m));
    end
    if (bus.newPress === 1'b1) begin
      pulse_cnt++;
      pulse_t.push_back(cyc);
      pulse_k.push_back(bus.keyNum);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  int last_strobe = 0;

  // Called at a falling edge; the byte is sampled on the following rising edge.
  task automatic send(input logic [7:0] b);
    bus.ps2_byte    = b;
    bus.ps2_byte_en = 1'b1;
    @(negedge clk);
    last_strobe     = cyc;
    bus.ps2_byte_en = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] bq[$]);
    foreach (bq[i]) begin
      bus.ps2_byte    = bq[i];
      bus.ps2_byte_en = 1'b1;
      @(negedge clk);
      last_strobe     = cyc;
    end
    bus.ps2_byte_en = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #1;
    chk("rst_keyNum", int'(bus.keyNum), 0);
    chk("rst_newPress", int'(bus.newPress), 0);
    chk("rst_pending", int'(bus.pending), 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] bq[$];
    int n0;
    bus.ps2_byte    = 8'h00;
    bus.ps2_byte_en = 1'b0;
    resetn          = 1'b0;
    tick(2);
    chk("init_keyNum", int'(bus.keyNum), 0);
    chk("init_newPress", int'(bus.newPress), 0);
    chk("init_pending", int'(bus.pending), 0);
    #2 resetn = 1'b1;
    tick(3);

    // First make of A: pulse one edge after the sampling edge.
    send(8'h1C);
    tick(3);
    chk("a_cnt", pulse_cnt, 1);
    chk("a_lat", pulse_t[0] - last_strobe, 1);
    chk("a_key", int'(pulse_k[0]), 7'b0000001);
    chk("a_pending", int'(bus.pending), 0);
    tick(1000);

    // Typematic repeats of a held key.
    n0 = pulse_cnt;
    repeat (3) begin send(8'h1C); tick(5); end
    tick(700);
    chk("rep_cnt", pulse_cnt - n0, 0);
    chk("rep_key", int'(bus.keyNum), 7'b0000001);

    // Break of A.
    send(8'hF0); send(8'h1C);
    tick(3);
    chk("brk_cnt", pulse_cnt, 2);
    chk("brk_lat", pulse_t[1] - last_strobe, 1);
    chk("brk_key", int'(pulse_k[1]), 7'b0000000);
    tick(1000);

    // E released, then G,C,A queued during holdoff: ascending order, 600 apart.
    send(8'h24);
    tick(10);
    bq = '{8'h34, 8'h21, 8'h1C};
    send_burst(bq);
    tick(2500);
    chk("bl_cnt", pulse_cnt, 6);
    chk("bl_k2", int'(pulse_k[2]), 7'b0010000);
    chk("bl_gap1", pulse_t[3] - pulse_t[2], 600);
    chk("bl_gap2", pulse_t[4] - pulse_t[3], 600);
    chk("bl_gap3", pulse_t[5] - pulse_t[4], 600);
    chk("bl_k3", int'(pulse_k[3]), 7'b0010001);
    chk("bl_k4", int'(pulse_k[4]), 7'b0010101);
    chk("bl_k5", int'(pulse_k[5]), 7'b1010101);

    // Release E, then press+release D within the holdoff: coalesced.
    send(8'hF0); send(8'h24);
    tick(3);
    chk("co_lat", pulse_t[6] - last_strobe, 1);
    chk("co_k6", int'(pulse_k[6]), 7'b1000101);
    send(8'h23); send(8'hF0); send(8'h23);
    tick(700);
    chk("co_cnt", pulse_cnt, 7);
    chk("co_pending", int'(bus.pending), 0);
    chk("co_key", int'(bus.keyNum), 7'b1000101);

    // Extended codes and unmapped bytes never touch the state.
    send(8'hE0); send(8'h32);
    send(8'hE0); send(8'hF0); send(8'h1C);
    send(8'h15);
    tick(700);
    chk("ext_cnt", pulse_cnt, 7);
    chk("ext_key", int'(bus.keyNum), 7'b1000101);
    chk("ext_pending", int'(bus.pending), 0);

    // Reset while in BREAK: next 0x1C is a make.
    send(8'hF0);
    pulse_reset();
    send(8'h1C);
    tick(3);
    chk("rb_cnt", pulse_cnt, 8);
    chk("rb_lat", pulse_t[7] - last_strobe, 1);
    chk("rb_key", int'(pulse_k[7]), 7'b0000001);

    // Reset during holdoff: the next change releases immediately.
    tick(10);
    pulse_reset();
    send(8'h32);
    tick(3);
    chk("rh_cnt", pulse_cnt, 9);
    chk("rh_lat", pulse_t[8] - last_strobe, 1);
    chk("rh_key", int'(pulse_k[8]), 7'b0000010);
    tick(700);

    // Byte landing on the same edge as a release: both take effect.
    bq = '{8'h2B, 8'h1C};
    send_burst(bq);
    tick(1300);
    chk("sm_cnt", pulse_cnt, 11);
    chk("sm_k9", int'(pulse_k[9]), 7'b0100010);
    chk("sm_k10", int'(pulse_k[10]), 7'b0100011);
    chk("sm_gap", pulse_t[10] - pulse_t[9], 600);
    chk("model_key", int'(key_m), 7'b0100011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
